// File: rtl/pixel_pkg.sv
// Shared types and helpers for the pixel stream transmitter and its raster counter.
package pixel_pkg;

  localparam int unsigned PIXEL_DATA_W = 8;

  // Literals carry a TX_ prefix so they cannot collide with the HBLANK/VBLANK parameters.
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_ACTIVE,
    TX_HBLANK,
    TX_VBLANK
  } tx_state_t;

  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned w;
    w = $clog2(value);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster x/y position counter with line/frame wrap and position flags.
module raster_counter
  import pixel_pkg::*;
#(
  parameter int unsigned WIDTH  = 1920,
  parameter int unsigned HEIGHT = 1080,
  parameter int unsigned XW     = clog2_min1(WIDTH),
  parameter int unsigned YW     = clog2_min1(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          sol,
  output logic          eol,
  output logic          sof,
  output logic          eof
);

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (advance) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x   = x_q;
  assign y   = y_q;
  assign sol = (x_q == '0);
  assign eol = (x_q == X_LAST);
  assign sof = (x_q == '0) && (y_q == '0);
  assign eof = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/pixel_stream_tx.sv
// Raster pixel source with programmable H/V blanking and line/frame markers.
// Define PIXEL_TX_TESTPAT_EN to replace the upstream port with an internal (x+y) gradient.
module pixel_stream_tx
  import pixel_pkg::*;
#(
  parameter int unsigned DATA_W = PIXEL_DATA_W,
  parameter int unsigned WIDTH  = 1920,
  parameter int unsigned HEIGHT = 1080,
  parameter int unsigned HBLANK = 4,
  parameter int unsigned VBLANK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_pixel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_pixel,
  output logic              out_valid,
  output logic              out_sol,
  output logic              out_eol,
  output logic              out_sof,
  output logic              out_eof,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       underrun_cnt
);

  localparam int unsigned XW        = clog2_min1(WIDTH);
  localparam int unsigned YW        = clog2_min1(HEIGHT);
  localparam int unsigned BLANK_MAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int unsigned BW        = clog2_min1(BLANK_MAX + 1);
  localparam logic [BW-1:0] H_LAST  = (HBLANK == 0) ? '0 : BW'(HBLANK - 1);
  // VBLANK=0 still spends one cycle here so frame_done lands the cycle after the eof pixel.
  localparam logic [BW-1:0] V_LAST  = (VBLANK == 0) ? '0 : BW'(VBLANK - 1);

  tx_state_t state_q, state_d;
  logic [BW-1:0]     blank_q, blank_d;
  logic [DATA_W-1:0] out_pixel_q, out_pixel_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sol_q, out_sol_d;
  logic              out_eol_q, out_eol_d;
  logic              out_sof_q, out_sof_d;
  logic              out_eof_q, out_eof_d;
  logic              frame_done_q, frame_done_d;
  logic [15:0]       underrun_q, underrun_d;

  logic              accept;
  logic              pos_clear;
  logic [XW-1:0]     pos_x;
  logic [YW-1:0]     pos_y;
  logic              pos_sol, pos_eol, pos_sof, pos_eof;
  logic [DATA_W-1:0] src_pixel;
  logic              src_valid;

`ifdef PIXEL_TX_TESTPAT_EN
  logic unused_upstream;
  assign unused_upstream = ^{in_pixel, in_valid};
  assign src_valid       = 1'b1;
  assign src_pixel       = DATA_W'(pos_x) + DATA_W'(pos_y);
`else
  logic unused_pos;
  assign unused_pos = ^{pos_x, pos_y};
  assign src_valid  = in_valid;
  assign src_pixel  = in_pixel;
`endif

  assign pos_clear = (state_q == TX_IDLE) && start;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .XW     (XW),
    .YW     (YW)
  ) u_raster_counter (
    .clk     (clk),
    .rst_n   (reset),
    .clear   (pos_clear),
    .advance (accept),
    .x       (pos_x),
    .y       (pos_y),
    .sol     (pos_sol),
    .eol     (pos_eol),
    .sof     (pos_sof),
    .eof     (pos_eof)
  );

  always_comb begin
    state_d      = state_q;
    blank_d      = blank_q;
    out_pixel_d  = out_pixel_q;
    out_valid_d  = 1'b0;
    out_sol_d    = 1'b0;
    out_eol_d    = 1'b0;
    out_sof_d    = 1'b0;
    out_eof_d    = 1'b0;
    frame_done_d = 1'b0;
    underrun_d   = underrun_q;
    accept       = 1'b0;

    case (state_q)
      TX_IDLE: begin
        if (start) begin
          state_d = TX_ACTIVE;
          blank_d = '0;
        end
      end
      TX_ACTIVE: begin
        if (src_valid) begin
          accept      = 1'b1;
          out_valid_d = 1'b1;
          out_pixel_d = src_pixel;
          out_sol_d   = pos_sol;
          out_eol_d   = pos_eol;
          out_sof_d   = pos_sof;
          out_eof_d   = pos_eof;
          if (pos_eof) begin
            state_d = TX_VBLANK;
            blank_d = '0;
          end else if (pos_eol && (HBLANK != 0)) begin
            state_d = TX_HBLANK;
            blank_d = '0;
          end
        end else if (underrun_q != 16'hFFFF) begin
          underrun_d = underrun_q + 16'd1;
        end
      end
      TX_HBLANK: begin
        if (blank_q == H_LAST) begin
          state_d = TX_ACTIVE;
          blank_d = '0;
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
      TX_VBLANK: begin
        if (blank_q == V_LAST) begin
          state_d      = TX_IDLE;
          blank_d      = '0;
          frame_done_d = 1'b1;
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= TX_IDLE;
      blank_q      <= '0;
      out_pixel_q  <= '0;
      out_valid_q  <= 1'b0;
      out_sol_q    <= 1'b0;
      out_eol_q    <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= '0;
    end else begin
      state_q      <= state_d;
      blank_q      <= blank_d;
      out_pixel_q  <= out_pixel_d;
      out_valid_q  <= out_valid_d;
      out_sol_q    <= out_sol_d;
      out_eol_q    <= out_eol_d;
      out_sof_q    <= out_sof_d;
      out_eof_q    <= out_eof_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign in_ready     = (state_q == TX_ACTIVE);
  assign busy         = (state_q != TX_IDLE);
  assign out_pixel    = out_pixel_q;
  assign out_valid    = out_valid_q;
  assign out_sol      = out_sol_q;
  assign out_eol      = out_eol_q;
  assign out_sof      = out_sof_q;
  assign out_eof      = out_eof_q;
  assign frame_done   = frame_done_q;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Directed bench for pixel_stream_tx: a 4x3 raster with and without blanking.
module tb_pixel_stream_tx;

  localparam int W = 4;
  localparam int H = 3;
`ifdef PIXEL_TX_TESTPAT_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, in_valid, sel;
  logic [7:0] in_pixel;
  logic       start_a, start_b;

  logic [7:0]  a_pix, b_pix;
  logic        a_rdy, a_val, a_sol, a_eol, a_sof, a_eof, a_busy, a_done;
  logic        b_rdy, b_val, b_sol, b_eol, b_sof, b_eof, b_busy, b_done;
  logic [15:0] a_und, b_und;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  pixel_stream_tx #(.DATA_W(8), .WIDTH(W), .HEIGHT(H), .HBLANK(2), .VBLANK(3)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .in_pixel(in_pixel), .in_valid(in_valid),
    .in_ready(a_rdy), .out_pixel(a_pix), .out_valid(a_val), .out_sol(a_sol), .out_eol(a_eol),
    .out_sof(a_sof), .out_eof(a_eof), .busy(a_busy), .frame_done(a_done), .underrun_cnt(a_und)
  );

  pixel_stream_tx #(.DATA_W(8), .WIDTH(W), .HEIGHT(H), .HBLANK(0), .VBLANK(0)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .in_pixel(in_pixel), .in_valid(in_valid),
    .in_ready(b_rdy), .out_pixel(b_pix), .out_valid(b_val), .out_sol(b_sol), .out_eol(b_eol),
    .out_sof(b_sof), .out_eof(b_eof), .busy(b_busy), .frame_done(b_done), .underrun_cnt(b_und)
  );

  logic [7:0]  o_pix;
  logic        o_rdy, o_val, o_busy, o_done;
  logic [3:0]  o_flg;
  logic [15:0] o_und;
  assign o_pix  = sel ? b_pix  : a_pix;
  assign o_rdy  = sel ? b_rdy  : a_rdy;
  assign o_val  = sel ? b_val  : a_val;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_done = sel ? b_done : a_done;
  assign o_und  = sel ? b_und  : a_und;
  assign o_flg  = sel ? {b_sol, b_eol, b_sof, b_eof} : {a_sol, a_eol, a_sof, a_eof};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [7:0] rec_pix[32];
  logic [3:0] rec_flg[32];
  int         rec_lc[32];
  int         n_out;
  int         done_lc;

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, o_val, 0);
    check({tag, "_pixel"}, o_pix, 0);
    check({tag, "_flags"}, o_flg, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_ready"}, o_rdy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_underrun"}, o_und, 0);
  endtask

  // Runs one frame; lc counts negedges from the start pulse. rst_k>=0 resets after pixel rst_k.
  task automatic run_frame(input bit s, input int stall_at, input int stall_len,
                           input int xstart_lc, input int rst_k, input int hb, input int vb);
    int next_pix, stalled, x, y, exp_lc, exp_pix;
    logic [3:0] exp_flg;
    sel = s; n_out = 0; done_lc = -1; next_pix = 0; stalled = 0;
    for (int lc = 0; lc < 80; lc++) begin
      @(negedge clk);
      if (lc > 0) begin
        if (o_val) begin
          if (n_out < 32) begin
            rec_pix[n_out] = o_pix; rec_flg[n_out] = o_flg; rec_lc[n_out] = lc;
          end
          if (n_out == 0) check("busy_active", o_busy, 1);
          n_out++;
        end else begin
          check($sformatf("idle_markers_lc%0d", lc), o_flg, 0);
        end
        if (o_done && done_lc < 0) begin
          done_lc = lc;
          check("busy_after_done", o_busy, 0);
        end else if (done_lc >= 0 && lc == done_lc + 1) begin
          check("done_one_cycle", o_done, 0);
          start = 1'b0;
          break;
        end
      end
      if (rst_k >= 0 && n_out == rst_k + 1) begin
        reset = 1'b0;
        start = 1'b0;
        #1;
        check_reset_state("midframe_reset");
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      start = (lc == 0) || (lc == xstart_lc);
      in_valid = 1'b1;
      if (o_rdy && next_pix == stall_at && stalled < stall_len) begin
        in_valid = 1'b0;
        stalled++;
      end
      in_pixel = next_pix[7:0];
      if (in_valid && o_rdy) next_pix++;
    end
    check("frame_done_seen", done_lc >= 0, 1);
    check("pixel_count", n_out, W * H);
    exp_lc = 0;
    for (int k = 0; k < W * H && k < n_out; k++) begin
      x = k % W;
      y = k / W;
      exp_pix = TP ? (x + y) : k;
      exp_flg = {x == 0, x == W - 1, k == 0, k == W * H - 1};
      exp_lc  = 2 + k + hb * y + ((!TP && stall_at >= 0 && k >= stall_at) ? stall_len : 0);
      check($sformatf("pix%0d_value", k), rec_pix[k], exp_pix);
      check($sformatf("pix%0d_markers", k), rec_flg[k], exp_flg);
      check($sformatf("pix%0d_cycle", k), rec_lc[k], exp_lc);
    end
    check("frame_done_cycle", done_lc, exp_lc + ((vb == 0) ? 1 : vb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_pixel = '0; sel = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset_a");
    sel = 1'b1;
    #1;
    check_reset_state("reset_b");
    sel = 1'b0;
    reset = 1'b1;

    run_frame(1'b0, -1, 0, -1, -1, 2, 3);
    check("underrun_clean", o_und, 0);

    run_frame(1'b0, 5, 2, -1, -1, 2, 3);
    check("underrun_stall", o_und, TP ? 0 : 2);

    run_frame(1'b1, -1, 0, -1, -1, 0, 0);
    check("underrun_noblank", o_und, 0);

    run_frame(1'b0, -1, 0, -1, 6, 2, 3);
    run_frame(1'b0, -1, 0, -1, -1, 2, 3);
    check("underrun_after_reset", o_und, 0);

    run_frame(1'b0, -1, 0, 6, -1, 2, 3);
    check("underrun_hblank_start", o_und, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
